// File: rtl/execute_pipe.sv
// execute_pipe: execute stage of the lc3b pipeline, between decode and mem.
//   Computes the ALU result, the effective address (base + offset, optionally
//   offset<<1) and NZP condition codes for the result. Results are held in an
//   output register so that mem-stage stalls back-pressure cleanly.
//
// Configuration macro: EXECUTE_MUL_EN
//   defined   : aluop 7 (MUL) runs an iterative shift-add multiplier,
//               latency WIDTH+1, busy high while it runs.
//   undefined : no multiplier; aluop 7 completes in one cycle with result 0.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
//   high. in_ready never depends on in_valid. out_valid, once high, stays high
//   with all out_* stable until a cycle with out_ready high; a new result may
//   load on that same edge. flush is synchronous and overrides everything.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   in_valid / in_ready    decode-side handshake
//   in_aluop               0 ADD,1 AND,2 NOT,3 PASS(b),4 SLL,5 SRL,6 SRA,7 MUL
//   in_a, in_b             operands (shift amount is in_b[SHAMT-1:0])
//   in_base, in_offset     address base and sign-extended offset
//   in_lshf                shift offset left by one before the add
//   in_dr, in_load_regfile, in_load_cc   forwarded writeback controls
//   flush                  squash held result and any in-flight multiply
//   out_valid / out_ready  mem-side handshake
//   out_result, out_address, out_cc, out_dr, out_load_regfile, out_load_cc
//   busy                   multiply in progress
//   dbg_state              FSM state (0 IDLE, 1 MUL_RUN, 2 MUL_HOLD)
module execute_pipe #(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 3,
  parameter int SHAMT    = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_aluop,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  input  logic [WIDTH-1:0]    in_base,
  input  logic [WIDTH-1:0]    in_offset,
  input  logic                in_lshf,
  input  logic [REG_BITS-1:0] in_dr,
  input  logic                in_load_regfile,
  input  logic                in_load_cc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_result,
  output logic [WIDTH-1:0]    out_address,
  output logic [2:0]          out_cc,
  output logic [REG_BITS-1:0] out_dr,
  output logic                out_load_regfile,
  output logic                out_load_cc,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL_RUN = 2'd1, MUL_HOLD = 2'd2} state_t;

  state_t r_state, w_next_state;

  logic                w_out_free;
  logic                w_accept;
  logic [SHAMT-1:0]    w_shamt;
  logic [WIDTH-1:0]    w_alu;
  logic [WIDTH-1:0]    w_offset;
  logic [WIDTH-1:0]    w_address;

  logic                w_ld;
  logic [WIDTH-1:0]    w_ld_result;
  logic [WIDTH-1:0]    w_ld_address;
  logic [REG_BITS-1:0] w_ld_dr;
  logic                w_ld_lr;
  logic                w_ld_lcc;

  function automatic logic [2:0] nzp(input logic [WIDTH-1:0] v);
    logic [2:0] cc;
    if (v[WIDTH-1])   cc = 3'b100;
    else if (v == '0) cc = 3'b010;
    else              cc = 3'b001;
    return cc;
  endfunction

  // The output slot is free when empty or being drained this cycle.
  assign w_out_free = ~out_valid | out_ready;
  assign in_ready   = (r_state == IDLE) & w_out_free & ~flush;
  assign w_accept   = in_valid & in_ready;
  assign busy       = (r_state != IDLE);
  assign dbg_state  = r_state;

  assign w_shamt = in_b[SHAMT-1:0];

  always_comb begin
    w_alu = '0;
    case (in_aluop)
      3'd0:    w_alu = in_a + in_b;
      3'd1:    w_alu = in_a & in_b;
      3'd2:    w_alu = ~in_a;
      3'd3:    w_alu = in_b;
      3'd4:    w_alu = in_a << w_shamt;
      3'd5:    w_alu = in_a >> w_shamt;
      3'd6:    w_alu = $unsigned($signed(in_a) >>> w_shamt);
      default: w_alu = '0;  // MUL: zero here; the multiplier supplies it when built
    endcase
  end

  assign w_offset  = in_lshf ? {in_offset[WIDTH-2:0], 1'b0} : in_offset;
  assign w_address = in_base + w_offset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

`ifdef EXECUTE_MUL_EN
  logic                w_is_mul;
  logic                w_mul_start;
  logic                w_mul_load;
  logic                w_mul_last;
  logic [WIDTH-1:0]    w_mul_sum;
  logic [WIDTH-1:0]    w_mul_final;
  logic [WIDTH-1:0]    r_mul_a;
  logic [WIDTH-1:0]    r_mul_b;
  logic [WIDTH-1:0]    r_mul_acc;
  logic [WIDTH-1:0]    r_mul_address;
  logic [REG_BITS-1:0] r_mul_dr;
  logic                r_mul_lr;
  logic                r_mul_lcc;
  logic [SHAMT-1:0]    r_cnt;

  assign w_is_mul   = (in_aluop == 3'd7);
  assign w_mul_sum  = r_mul_acc + (r_mul_b[0] ? r_mul_a : '0);
  assign w_mul_last = (r_cnt == SHAMT'(WIDTH - 1));
  // In MUL_RUN the last partial sum is still combinational; in MUL_HOLD it
  // has already been captured in the accumulator.
  assign w_mul_final = (r_state == MUL_RUN) ? w_mul_sum : r_mul_acc;

  always_comb begin
    w_next_state = r_state;
    w_mul_start  = 1'b0;
    w_mul_load   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && w_is_mul) begin
          w_next_state = MUL_RUN;
          w_mul_start  = 1'b1;
        end
      end
      MUL_RUN: begin
        if (w_mul_last) begin
          if (w_out_free) begin
            w_mul_load   = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_next_state = MUL_HOLD;
          end
        end
      end
      MUL_HOLD: begin
        if (w_out_free) begin
          w_mul_load   = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
    if (flush) begin
      w_next_state = IDLE;
      w_mul_start  = 1'b0;
      w_mul_load   = 1'b0;
    end
  end

  // Shift-add: multiplicand moves left, multiplier right, one bit per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mul_a       <= '0;
      r_mul_b       <= '0;
      r_mul_acc     <= '0;
      r_mul_address <= '0;
      r_mul_dr      <= '0;
      r_mul_lr      <= 1'b0;
      r_mul_lcc     <= 1'b0;
      r_cnt         <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_mul_start) begin
      r_mul_a       <= in_a;
      r_mul_b       <= in_b;
      r_mul_acc     <= '0;
      r_mul_address <= w_address;
      r_mul_dr      <= in_dr;
      r_mul_lr      <= in_load_regfile;
      r_mul_lcc     <= in_load_cc;
      r_cnt         <= '0;
    end else if (r_state == MUL_RUN) begin
      r_mul_acc <= w_mul_sum;
      r_mul_a   <= r_mul_a << 1;
      r_mul_b   <= r_mul_b >> 1;
      r_cnt     <= r_cnt + 1'b1;
    end
  end

  assign w_ld         = (w_accept & ~w_is_mul) | w_mul_load;
  assign w_ld_result  = w_mul_load ? w_mul_final   : w_alu;
  assign w_ld_address = w_mul_load ? r_mul_address : w_address;
  assign w_ld_dr      = w_mul_load ? r_mul_dr      : in_dr;
  assign w_ld_lr      = w_mul_load ? r_mul_lr      : in_load_regfile;
  assign w_ld_lcc     = w_mul_load ? r_mul_lcc     : in_load_cc;
`else
  always_comb begin
    w_next_state = IDLE;
  end

  assign w_ld         = w_accept;
  assign w_ld_result  = w_alu;
  assign w_ld_address = w_address;
  assign w_ld_dr      = in_dr;
  assign w_ld_lr      = in_load_regfile;
  assign w_ld_lcc     = in_load_cc;
`endif

  // Output register: data only changes on a load, so a stalled result holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid        <= 1'b0;
      out_result       <= '0;
      out_address      <= '0;
      out_cc           <= '0;
      out_dr           <= '0;
      out_load_regfile <= 1'b0;
      out_load_cc      <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_ld) begin
      out_valid        <= 1'b1;
      out_result       <= w_ld_result;
      out_address      <= w_ld_address;
      out_cc           <= nzp(w_ld_result);
      out_dr           <= w_ld_dr;
      out_load_regfile <= w_ld_lr;
      out_load_cc      <= w_ld_lcc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
